// File: rtl/trace_commit_buffer_if.sv
// Trace output stream: valid/ready handshake plus the timestamped entry payload.
interface trace_commit_buffer_if #(
  parameter int unsigned TS_W   = 32,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned ID_W   = 10,
  parameter int unsigned DATA_W = 128
);
  logic              out_valid;
  logic              out_ready;
  logic [TS_W-1:0]   out_ts;
  logic [CH_W-1:0]   out_ch;
  logic [ID_W-1:0]   out_id;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid, out_ts, out_ch, out_id, out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_ts, out_ch, out_id, out_data,
    output out_ready
  );
endinterface

// File: rtl/trace_commit_buffer.sv
// Timestamps architectural write events from several channels, buffers them in a FWFT FIFO
// and streams them to a trace sink; counts lost events and signals when a halt drain completes.
module trace_commit_buffer #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ID_W   = 10,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 32,
  parameter int unsigned DROP_W = 16,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        wr_valid,
  input  logic [NUM_CH*ID_W-1:0]   wr_id,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic                     halt,
  trace_commit_buffer_if.master    trace,
  output logic [LVL_W-1:0]         level,
  output logic [DROP_W-1:0]        drop_count,
  output logic                     done
);

  localparam int unsigned PTR_W = LVL_W - 1;
  localparam int unsigned CNT_W = $clog2(NUM_CH + 1);
  localparam int unsigned SUM_W = DROP_W + CNT_W;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [CH_W-1:0]   ch;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e              state_q;
  logic                done_q;
  logic [TS_W-1:0]     ts_q;
  logic [NUM_CH-1:0]   hold_v_q;
  entry_t              hold_q [NUM_CH];
  entry_t              mem_q  [DEPTH];
  logic [LVL_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic                empty, full, pop, push, push_found;
  logic [CH_W-1:0]     push_sel;
  entry_t              push_entry, head;
  logic [NUM_CH-1:0]   load;
  logic [CNT_W-1:0]    drop_n;
  logic [SUM_W-1:0]    drop_sum;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));
  assign pop   = ~empty & trace.out_ready;

  // Lowest-index occupied hold wins the single FIFO write port.
  always_comb begin
    push_found = 1'b0;
    push_sel   = '0;
    push_entry = '0;
    for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
      if (hold_v_q[c]) begin
        push_found = 1'b1;
        push_sel   = CH_W'(c);
        push_entry = hold_q[c];
      end
    end
  end

  assign push = push_found & (~full | pop);

  always_comb begin
    load   = '0;
    drop_n = '0;
    if (state_q == StRun) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (wr_valid[c] && ch_en[c]) begin
          if (!hold_v_q[c] || (push && push_sel == CH_W'(c))) begin
            load[c] = 1'b1;
          end else begin
            drop_n = drop_n + CNT_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    drop_sum = SUM_W'(drop_q) + SUM_W'(drop_n);
    drop_d   = (drop_sum > SUM_W'({DROP_W{1'b1}})) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      ts_q   <= ts_q + TS_W'(1);
      drop_q <= drop_d;
      if (push) wr_ptr_q <= wr_ptr_q + LVL_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v_q <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) hold_q[c] <= '0;
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (load[c]) begin
          hold_v_q[c] <= 1'b1;
          hold_q[c]   <= {ts_q, CH_W'(c), wr_id[c*ID_W +: ID_W], wr_data[c*DATA_W +: DATA_W]};
        end else if (push && push_sel == CH_W'(c)) begin
          hold_v_q[c] <= 1'b0;
        end
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (halt) state_q <= StDrain;
        end
        StDrain: begin
          if (empty && hold_v_q == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= StRun;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

  assign trace.out_valid = ~empty;
  assign trace.out_ts    = head.ts;
  assign trace.out_ch    = head.ch;
  assign trace.out_id    = head.id;
  assign trace.out_data  = head.data;
  assign drop_count      = drop_q;
  assign done            = done_q;

endmodule

// File: tb/tb_trace_commit_buffer.sv
// Randomized and directed stimulus for trace_commit_buffer, checked by a queue-based
// reference model and a scoreboard monitor that compares every accepted output entry.
module tb_trace_commit_buffer;
  localparam int NUM_CH = 3;
  localparam int ID_W   = 10;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 32;
  localparam int CH_W   = 2;
  localparam int LVL_W  = 5;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        ch_en = '1;
  logic [NUM_CH-1:0]        wr_valid = '0;
  logic [NUM_CH*ID_W-1:0]   wr_id = '0;
  logic [NUM_CH*DATA_W-1:0] wr_data = '0;
  logic                     halt = 1'b0;
  logic [LVL_W-1:0]         level, level2;
  logic [15:0]              drop_count;
  logic [1:0]               drop_count2;
  logic                     done, done2;

  trace_commit_buffer_if #(.TS_W(TS_W), .CH_W(CH_W), .ID_W(ID_W), .DATA_W(DATA_W)) tif ();
  trace_commit_buffer_if #(.TS_W(TS_W), .CH_W(CH_W), .ID_W(ID_W), .DATA_W(DATA_W)) tif2 ();

  assign tif2.out_ready = tif.out_ready;

  trace_commit_buffer #(
    .NUM_CH(NUM_CH), .ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(16)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .wr_valid(wr_valid), .wr_id(wr_id),
    .wr_data(wr_data), .halt(halt), .trace(tif), .level(level), .drop_count(drop_count),
    .done(done)
  );

  // Narrow drop counter instance shares all stimulus to exercise saturation.
  trace_commit_buffer #(
    .NUM_CH(NUM_CH), .ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(2)
  ) dut2 (
    .clk(clk), .rst(rst), .ch_en(ch_en), .wr_valid(wr_valid), .wr_id(wr_id),
    .wr_data(wr_data), .halt(halt), .trace(tif2), .level(level2), .drop_count(drop_count2),
    .done(done2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [TS_W-1:0]   ts;
    logic [CH_W-1:0]   ch;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t            exp_q[$];
  ent_t            m_hold [NUM_CH];
  bit              m_hv   [NUM_CH];
  int              m_cnt;
  longint          m_drops;
  int              m_state;  // 0 run, 1 drain, 2 done
  logic [TS_W-1:0] m_ts;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) m_hv[c] = 1'b0;
    m_cnt   = 0;
    m_drops = 0;
    m_state = 0;
    m_ts    = '0;
  endtask

  // One clock edge of the reference: each channel owns a one-deep slot, the FIFO is a
  // bounded queue of DEPTH, and one slot (lowest channel first) may enter it per edge.
  task automatic model_step();
    bit pop;
    bit idle;
    int sel;
    pop  = (m_cnt > 0) && tif.out_ready;
    sel  = -1;
    idle = (m_cnt == 0);
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_hv[c]) begin
        idle = 1'b0;
        if (sel < 0) sel = c;
      end
    end
    if (sel >= 0 && (m_cnt < DEPTH || pop)) begin
      exp_q.push_back(m_hold[sel]);
      m_hv[sel] = 1'b0;
      m_cnt++;
    end
    if (pop) m_cnt--;
    if (m_state == 0) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_valid[c] && ch_en[c]) begin
          if (m_hv[c]) m_drops++;
          else begin
            m_hold[c] = '{m_ts, CH_W'(c), wr_id[c*ID_W +: ID_W], wr_data[c*DATA_W +: DATA_W]};
            m_hv[c]   = 1'b1;
          end
        end
      end
    end
    if (m_state == 0 && halt) m_state = 1;
    else if (m_state == 1 && idle) m_state = 2;
    m_ts = m_ts + 1'b1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Scoreboard monitor: status every cycle, payload on every accepted transfer.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("out_valid", tif.out_valid, m_cnt != 0);
        chk("level", level, m_cnt);
        chk("drop_count", drop_count, (m_drops > 65535) ? 65535 : m_drops);
        chk("drop_count_sat2", drop_count2, (m_drops > 3) ? 3 : m_drops);
        chk("done", done, m_state == 2);
        if (tif.out_valid && tif.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_entry", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("out_ts", tif.out_ts, e.ts);
            chk("out_ch", tif.out_ch, e.ch);
            chk("out_id", tif.out_id, e.id);
            chk("out_data", tif.out_data, e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ch(input int c, input logic v, input logic [ID_W-1:0] id,
                        input logic [DATA_W-1:0] d);
    wr_valid[c]                = v;
    wr_id[c*ID_W +: ID_W]      = id;
    wr_data[c*DATA_W +: DATA_W] = d;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    wr_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    tif.out_ready = 1'b0;
    #22 rst = 1'b0;

    // Single event sampled at ts=3, visible two edges later.
    step(); step(); step();
    set_ch(1, 1'b1, 10'd5, 128'hA5);
    step();
    wr_valid = '0;
    step();
    chk("t1_valid", tif.out_valid, 1'b1);
    chk("t1_ts", tif.out_ts, 3);
    chk("t1_ch", tif.out_ch, 1);
    chk("t1_id", tif.out_id, 5);
    chk("t1_data", tif.out_data, 128'hA5);
    chk("t1_level", level, 1);
    tif.out_ready = 1'b1;
    step();
    chk("t1_level_after_pop", level, 0);

    // Three channels in one cycle.
    set_ch(0, 1'b1, 10'd1, rnd_data());
    set_ch(1, 1'b1, 10'd2, rnd_data());
    set_ch(2, 1'b1, 10'd3, rnd_data());
    step();
    idle(6);
    chk("t2_drops", drop_count, 0);

    // Fill FIFO and hold, then overflow three times.
    tif.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_ch(0, 1'b1, ID_W'(i), rnd_data());
      step();
    end
    wr_valid = '0;
    chk("t3_level_full", level, 16);
    chk("t3_drops", drop_count, 3);
    tif.out_ready = 1'b1;
    idle(20);
    chk("t3_drained", level, 0);

    // Masked channel never captures or drops.
    ch_en = 3'b011;
    for (int i = 0; i < 5; i++) begin
      set_ch(2, 1'b1, ID_W'(50 + i), rnd_data());
      if (i == 2) set_ch(0, 1'b1, 10'd77, rnd_data());
      step();
      wr_valid[0] = 1'b0;
    end
    idle(4);
    chk("t4_drops_masked", drop_count, 3);
    ch_en = 3'b111;

    // Force many drops; the narrow counter must stick at all-ones.
    tif.out_ready = 1'b0;
    for (int i = 0; i < 25; i++) begin
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b1, ID_W'($urandom), rnd_data());
      step();
    end
    chk("t4_sat2", drop_count2, 3);
    tif.out_ready = 1'b1;
    idle(30);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'($urandom), ID_W'($urandom), rnd_data());
      tif.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    tif.out_ready = 1'b1;
    idle(30);

    // Halt with a same-cycle write, post-halt writes are ignored.
    tif.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 1'b1, ID_W'(100 + i), rnd_data());
      step();
    end
    wr_valid = '0;
    set_ch(1, 1'b1, 10'd200, rnd_data());
    halt = 1'b1;
    step();
    halt = 1'b0;
    wr_valid = '0;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, 1'b1, ID_W'(300 + i), rnd_data());
      step();
    end
    wr_valid = '0;
    tif.out_ready = 1'b1;
    for (int i = 0; i < 60 && !done; i++) step();
    chk("t5_done_reached", done, 1'b1);
    chk("t5_all_emerged", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      halt = 1'b1;
      set_ch(2, 1'b1, 10'd9, rnd_data());
      step();
      halt = 1'b0;
      wr_valid = '0;
      step();
    end
    chk("t5_done_held", done, 1'b1);
    chk("t5_valid_low", tif.out_valid, 1'b0);

    // Async reset mid-cycle with buffered entries and a nonzero drop count.
    rst = 1'b1;
    step();
    rst = 1'b0;
    tif.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_ch(0, 1'b1, ID_W'(400 + i), rnd_data());
      set_ch(1, i < 2, 10'd500, rnd_data());
      step();
    end
    idle(1);
    chk("t6_level7", level, 7);
    chk("t6_drop1", drop_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", tif.out_valid, 1'b0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_drops", drop_count, 0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_data", tif.out_data, 0);
    #2 rst = 1'b0;
    set_ch(2, 1'b1, 10'h3FF, 128'hDEAD_BEEF);
    tif.out_ready = 1'b1;
    step();
    wr_valid = '0;
    step();
    chk("t6_first_ts", tif.out_ts, 0);
    chk("t6_first_ch", tif.out_ch, 2);
    idle(5);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
